// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/mask buses and the memory arbiter state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    // Byte mask driven for instruction fetches: always a full word.
    localparam lc3b_mem_wmask FETCH_WMASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-into-one arbiter: instruction (I) and data (D) ports share one physical memory, round-robin on contention.
// Latency: request sampled at edge N -> pmem strobe from cycle N+1; resp returned combinationally in the pmem_resp cycle.
// Backpressure: requesters hold until their resp; a losing or late request simply waits, nothing is dropped.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   i_read/i_address               fetch read request (held until i_resp)
//   i_resp/i_rdata                 fetch completion pulse and read data
//   d_read/d_write/d_wmask/
//   d_address/d_wdata              data request (held until d_resp)
//   d_resp/d_rdata                 data completion pulse and read data
//   pmem_read/pmem_write/pmem_wmask/
//   pmem_address/pmem_wdata        registered physical memory request
//   pmem_resp/pmem_rdata           physical completion pulse and read data
module mem_arbiter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          reset,

    input  logic          i_read,
    input  lc3b_word      i_address,
    output logic          i_resp,
    output lc3b_word      i_rdata,

    input  logic          d_read,
    input  logic          d_write,
    input  lc3b_mem_wmask d_wmask,
    input  lc3b_word      d_address,
    input  lc3b_word      d_wdata,
    output logic          d_resp,
    output lc3b_word      d_rdata,

    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_mem_wmask pmem_wmask,
    output lc3b_word      pmem_address,
    output lc3b_word      pmem_wdata,
    input  logic          pmem_resp,
    input  lc3b_word      pmem_rdata
);

    arb_state_t    r_state;
    logic          r_last_grant;   // 0: I served last, 1: D served last
    logic          r_pmem_read;
    logic          r_pmem_write;
    lc3b_mem_wmask r_pmem_wmask;
    lc3b_word      r_pmem_address;
    lc3b_word      r_pmem_wdata;

    arb_state_t    w_next_state;
    logic          w_i_req;
    logic          w_d_req;
    logic          w_grant_i;
    logic          w_grant_d;

    always_comb begin
        w_i_req      = i_read;
        w_d_req      = d_read | d_write;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                // On contention the side that was not served last wins.
                if (w_i_req && (!w_d_req || r_last_grant)) begin
                    w_grant_i    = 1'b1;
                    w_next_state = SERVE_I;
                end else if (w_d_req) begin
                    w_grant_d    = 1'b1;
                    w_next_state = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase

        // A pmem_resp seen while idle (e.g. after a reset abandoned a transaction) is dropped here.
        i_resp = pmem_resp && (r_state == SERVE_I);
        d_resp = pmem_resp && (r_state == SERVE_D);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_last_grant   <= 1'b1;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_wmask   <= '0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
        end else begin
            r_state <= w_next_state;
            // Request fields are captured once at grant so mid-flight requester changes cannot leak out.
            if (w_grant_i) begin
                r_pmem_read    <= 1'b1;
                r_pmem_write   <= 1'b0;
                r_pmem_wmask   <= FETCH_WMASK;
                r_pmem_address <= i_address;
            end else if (w_grant_d) begin
                // Write takes priority if the MEM stage raises both strobes.
                r_pmem_read    <= ~d_write;
                r_pmem_write   <= d_write;
                r_pmem_wmask   <= d_wmask;
                r_pmem_address <= d_address;
                r_pmem_wdata   <= d_wdata;
            end
            if ((r_state != IDLE) && pmem_resp) begin
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
                r_last_grant <= (r_state == SERVE_D);
            end
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_wmask   = r_pmem_wmask;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

    // Read data passes straight through; only meaningful alongside the matching resp.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-into-one memory arbiter that lets the LC-3b pipeline's instruction port (fetch side) and data port (MEM stage) share a single physical memory interface. It sits between the datapath's port-a/port-b memory signals and the one physical memory, and serialises their requests. It grants round-robin when both ports request together. It holds each granted transaction stable until the memory responds, then returns a one-cycle response to the owner.

## Interface
Parameters:
- none; all widths come from `lc3b_types` (`lc3b_word` = 16 bits).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_read  in  1  instruction-side read request; held until `i_resp`.
- i_address  in  16  instruction address.
- i_resp  out  1  instruction-side completion pulse.
- i_rdata  out  16  instruction read data; valid when `i_resp`=1.
- d_read  in  1  data-side read request; held until `d_resp`.
- d_write  in  1  data-side write request; held until `d_resp`.
- d_wmask  in  2  byte-write mask for `d_write`.
- d_address  in  16  data address.
- d_wdata  in  16  data write value.
- d_resp  out  1  data-side completion pulse.
- d_rdata  out  16  data read data; valid when `d_resp`=1.
- pmem_read  out  1  physical read strobe.
- pmem_write  out  1  physical write strobe.
- pmem_wmask  out  2  physical byte mask.
- pmem_address  out  16  physical address.
- pmem_wdata  out  16  physical write data.
- pmem_resp  in  1  physical completion (one-cycle pulse).
- pmem_rdata  in  16  physical read data.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - SERVE_I: fetch transaction in flight.
  - SERVE_D: data transaction in flight.
  - Reset state: IDLE.
- `last_grant` flop: 0 = I was last served, 1 = D was last served. Reset value 1, so I wins the first contested cycle.
- IDLE arbitration:
  - Only I requests: go to SERVE_I.
  - Only D requests (`d_read|d_write`): go to SERVE_D.
  - Both request: grant the side not in `last_grant`.
  - Neither requests: stay in IDLE.
- At grant, register `pmem_address`, `pmem_wdata`, `pmem_wmask`, `pmem_read` and `pmem_write` from the winning requester. They stay constant for the whole transaction, even if requester inputs change.
- Request types on pmem:
  - I grant: `pmem_read`=1, `pmem_write`=0, `pmem_wmask`=2'b11.
  - D grant with `d_write`=1: `pmem_write`=1, `pmem_read`=0. Write wins if `d_read` and `d_write` are both high.
  - D grant with `d_read` only: `pmem_read`=1.
- In SERVE_x with `pmem_resp`=1:
  - `x_resp`=1 combinationally.
  - `x_rdata` = `pmem_rdata`.
  - `last_grant` updates to the served side.
  - State returns to IDLE; the registered pmem strobes clear on the same edge.
- Responses are gated:
  - `i_resp` = `pmem_resp` & (state==SERVE_I).
  - `d_resp` = `pmem_resp` & (state==SERVE_D).
  - `pmem_resp` in IDLE is ignored.
- `i_rdata`/`d_rdata` pass `pmem_rdata` through at all times; they are meaningful only with the matching resp.
- A request still high in the cycle after its resp is treated as a new request.
- Reset values: `pmem_read`=`pmem_write`=0, `pmem_wmask`=0, `pmem_address`=0, `pmem_wdata`=0, `i_resp`=`d_resp`=0.

## Timing
- Grant latency: request sampled high at edge N means pmem strobe is high from cycle N+1 (registered outputs, no combinational path request→pmem).
- Strobe duration: held through the cycle where `pmem_resp`=1 inclusive, low the next cycle.
- Minimum gap: one IDLE cycle between back-to-back transactions. Peak throughput is one transaction per (memory latency + 1) cycles.
- Simultaneous events:
  - Requests from both sides arriving in the same IDLE cycle: resolved by `last_grant`.
  - A new request arriving while busy: waits, no loss.
- Fairness bound: a persistently requesting side waits for at most one opposite-side transaction.
- Reset mid-transaction: next edge forces IDLE and clears the strobes. The abandoned transaction produces no resp, and a late `pmem_resp` is ignored.

## Structure
- Add `arb_state_t` enum {IDLE, SERVE_I, SERVE_D} to `lc3b_types`; `lc3b_word` reused for all 16-bit buses.
- Single module: one `always_ff` for state/`last_grant`/pmem registers, one `always_comb` for next-state and resp gating; no sub-module.

## Test plan
- I-only: after reset, `i_read`=1, `i_address`=16'h0040, memory replies 3 cycles later with 16'h1234 → `pmem_read`=1 with address 16'h0040 from cycle 1 through the resp cycle; `i_resp` pulses once with `i_rdata`=16'h1234.
- D write: `d_write`=1, `d_address`=16'h0100, `d_wdata`=16'hBEEF, `d_wmask`=2'b01 → `pmem_write`=1 with those values; `pmem_read`=0; `d_resp` pulses once; `i_resp` stays 0.
- Contention: both request at reset exit → I served first, then D after one IDLE cycle; repeat with both held → strict alternation I,D,I,D.
- Input change mid-flight: change `d_address` during SERVE_D → `pmem_address` holds the granted value until resp.
- Reset mid-op: assert `reset` during SERVE_I, then `pmem_resp` arrives → state IDLE, strobes 0 next cycle, no `i_resp`.
- Read+write both high on D → write issued, `pmem_read`=0.
